// File: rtl/johnson_ring_counter_if.sv
// Control and status bundle for johnson_ring_counter.
// master drives en/mode/dir/load/load_val; slave (the counter) returns cnt/state_idx/wrap/illegal.
// No flow control: every input is sampled on each rising edge.
interface johnson_ring_counter_if #(
    parameter int WIDTH = 4,
    parameter int IDXW  = $clog2(2 * WIDTH)
);
    logic             en;
    logic             mode;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] cnt;
    logic [IDXW-1:0]  state_idx;
    logic             wrap;
    logic             illegal;

    modport master (
        output en, mode, dir, load, load_val,
        input  cnt, state_idx, wrap, illegal
    );

    modport slave (
        input  en, mode, dir, load, load_val,
        output cnt, state_idx, wrap, illegal
    );
endinterface

// File: rtl/johnson_ring_counter.sv
// Parametrised Johnson / one-hot ring sequencer with index decode, wrap pulse and illegal-state flag.
// Latency: one shift per enabled edge; state_idx/illegal are combinational, wrap is registered.
// No backpressure; `JOHNSON_SELFCORRECT_EN makes an enabled illegal state jump back to S0.
module johnson_ring_counter #(
    parameter int WIDTH = 4,
    parameter int IDXW  = $clog2(2 * WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    johnson_ring_counter_if.slave bus
);

    localparam int CW = IDXW + 1;

    if (WIDTH < 2) begin : g_bad_width
        $error("johnson_ring_counter: WIDTH must be at least 2");
    end

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;

    logic [WIDTH-1:0] s0;
    logic [WIDTH-1:0] shift_val;
    logic [CW-1:0]    ones;
    logic [CW-1:0]    edges;
    logic [IDXW-1:0]  ring_idx;
    logic [IDXW-1:0]  johnson_idx;
    logic             johnson_ok;
    logic             ring_ok;
    logic             illegal;

    assign s0 = bus.mode ? WIDTH'(1) : '0;

    // Popcount and count of adjacent-bit transitions drive both legality and index decode.
    always_comb begin
        ones  = '0;
        edges = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + CW'(cnt_q[i]);
        end
        for (int i = 0; i < WIDTH - 1; i++) begin
            edges = edges + CW'(cnt_q[i] ^ cnt_q[i+1]);
        end
    end

    always_comb begin
        ring_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (cnt_q[i]) begin
                ring_idx = IDXW'(i);
            end
        end
    end

    assign johnson_ok  = (edges <= CW'(1));
    assign ring_ok     = (ones == CW'(1));
    assign illegal     = bus.mode ? !ring_ok : !johnson_ok;
    // Upper half of the Johnson cycle counts back down from 2*WIDTH as ones drain out of the LSB end.
    assign johnson_idx = cnt_q[WIDTH-1] ? IDXW'(CW'(2 * WIDTH) - ones) : IDXW'(ones);

    always_comb begin
        shift_val = cnt_q;
        unique case ({bus.mode, bus.dir})
            2'b00: shift_val = {cnt_q[WIDTH-2:0], ~cnt_q[WIDTH-1]};
            2'b01: shift_val = {~cnt_q[0], cnt_q[WIDTH-1:1]};
            2'b10: shift_val = {cnt_q[WIDTH-2:0], cnt_q[WIDTH-1]};
            2'b11: shift_val = {cnt_q[0], cnt_q[WIDTH-1:1]};
            default: shift_val = cnt_q;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (bus.load) begin
            cnt_d = bus.load_val;
`ifdef JOHNSON_SELFCORRECT_EN
        end else if (bus.en && illegal) begin
            cnt_d = s0;
`endif
        end else if (bus.en) begin
            cnt_d  = shift_val;
            // Shifts preserve illegality, so only a legal state may announce a wrap.
            wrap_d = !illegal && (shift_val == s0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= s0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.cnt       = cnt_q;
    assign bus.wrap      = wrap_q;
    assign bus.illegal   = illegal;
    assign bus.state_idx = illegal ? '0 : (bus.mode ? ring_idx : johnson_idx);

endmodule

// File: tb/tb_johnson_ring_counter.sv
// Directed table-driven bench for johnson_ring_counter at WIDTH=4, plus a hand-written mode-switch sequence.
module tb_johnson_ring_counter;

    localparam int WIDTH = 4;
    localparam int IDXW  = $clog2(2 * WIDTH);

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    johnson_ring_counter_if #(.WIDTH(WIDTH), .IDXW(IDXW)) bus ();

    johnson_ring_counter #(.WIDTH(WIDTH), .IDXW(IDXW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string            name;
        logic             rst;
        logic             en;
        logic             mode;
        logic             dir;
        logic             load;
        logic [WIDTH-1:0] lv;
        logic [WIDTH-1:0] cnt;
        logic [IDXW-1:0]  idx;
        logic             wrap;
        logic             ill;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic r, input logic e, input logic m,
                       input logic d, input logic l, input logic [WIDTH-1:0] lv,
                       input logic [WIDTH-1:0] c, input logic [IDXW-1:0] ix,
                       input logic w, input logic il);
        vec_t v;
        v.name = name; v.rst = r; v.en = e; v.mode = m; v.dir = d; v.load = l; v.lv = lv;
        v.cnt = c; v.idx = ix; v.wrap = w; v.ill = il;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string name, input logic [WIDTH-1:0] c,
                                 input logic [IDXW-1:0] ix, input logic w, input logic il);
        check({name, ".cnt"},     32'(bus.cnt),       32'(c));
        check({name, ".idx"},     32'(bus.state_idx), 32'(ix));
        check({name, ".wrap"},    32'(bus.wrap),      32'(w));
        check({name, ".illegal"}, 32'(bus.illegal),   32'(il));
    endtask

    initial begin
        rst          = 1'b1;
        bus.en       = 1'b0;
        bus.mode     = 1'b0;
        bus.dir      = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = '0;

        //   name         rst en md dr ld lv       cnt      idx wr il
        add("rst_j",       1, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
        add("jl1",         0, 1, 0, 0, 0, 4'b0000, 4'b0001, 1, 0, 0);
        add("jl2",         0, 1, 0, 0, 0, 4'b0000, 4'b0011, 2, 0, 0);
        add("jl3",         0, 1, 0, 0, 0, 4'b0000, 4'b0111, 3, 0, 0);
        add("jl4",         0, 1, 0, 0, 0, 4'b0000, 4'b1111, 4, 0, 0);
        add("jl5",         0, 1, 0, 0, 0, 4'b0000, 4'b1110, 5, 0, 0);
        add("jl6",         0, 1, 0, 0, 0, 4'b0000, 4'b1100, 6, 0, 0);
        add("jl7",         0, 1, 0, 0, 0, 4'b0000, 4'b1000, 7, 0, 0);
        add("jl_wrap",     0, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 0);
        add("jr1",         0, 1, 0, 1, 0, 4'b0000, 4'b1000, 7, 0, 0);
        add("jr2",         0, 1, 0, 1, 0, 4'b0000, 4'b1100, 6, 0, 0);
        add("jr3",         0, 1, 0, 1, 0, 4'b0000, 4'b1110, 5, 0, 0);
        add("jr4",         0, 1, 0, 1, 0, 4'b0000, 4'b1111, 4, 0, 0);
        add("jr5",         0, 1, 0, 1, 0, 4'b0000, 4'b0111, 3, 0, 0);
        add("jr6",         0, 1, 0, 1, 0, 4'b0000, 4'b0011, 2, 0, 0);
        add("jr7",         0, 1, 0, 1, 0, 4'b0000, 4'b0001, 1, 0, 0);
        add("jr_wrap",     0, 1, 0, 1, 0, 4'b0000, 4'b0000, 0, 1, 0);
        add("rst_r",       1, 0, 1, 0, 0, 4'b0000, 4'b0001, 0, 0, 0);
        add("rl1",         0, 1, 1, 0, 0, 4'b0000, 4'b0010, 1, 0, 0);
        add("rl2",         0, 1, 1, 0, 0, 4'b0000, 4'b0100, 2, 0, 0);
        add("rl3",         0, 1, 1, 0, 0, 4'b0000, 4'b1000, 3, 0, 0);
        add("rl_wrap",     0, 1, 1, 0, 0, 4'b0000, 4'b0001, 0, 1, 0);
        add("hold1",       0, 0, 1, 0, 0, 4'b0000, 4'b0001, 0, 0, 0);
        add("hold2",       0, 0, 1, 0, 0, 4'b0000, 4'b0001, 0, 0, 0);
        add("hold3",       0, 0, 1, 0, 0, 4'b0000, 4'b0001, 0, 0, 0);
        add("load_over_en",0, 1, 0, 0, 1, 4'b0111, 4'b0111, 3, 0, 0);
        add("rst_over_ld", 1, 1, 0, 0, 1, 4'b0111, 4'b0000, 0, 0, 0);
        add("load_ill",    0, 0, 0, 0, 1, 4'b0101, 4'b0101, 0, 0, 1);
`ifdef JOHNSON_SELFCORRECT_EN
        add("ill_step",    0, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
`else
        add("ill_step",    0, 1, 0, 0, 0, 4'b0000, 4'b1011, 0, 0, 1);
`endif
        add("rst_mid0",    1, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
        add("mid1",        0, 1, 0, 0, 0, 4'b0000, 4'b0001, 1, 0, 0);
        add("mid2",        0, 1, 0, 0, 0, 4'b0000, 4'b0011, 2, 0, 0);
        add("mid3",        0, 1, 0, 0, 0, 4'b0000, 4'b0111, 3, 0, 0);
        add("mid4",        0, 1, 0, 0, 0, 4'b0000, 4'b1111, 4, 0, 0);
        add("mid5",        0, 1, 0, 0, 0, 4'b0000, 4'b1110, 5, 0, 0);
        add("rst_mid",     1, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
        add("ms1",         0, 1, 0, 0, 0, 4'b0000, 4'b0001, 1, 0, 0);
        add("ms2",         0, 1, 0, 0, 0, 4'b0000, 4'b0011, 2, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst          = vecs[i].rst;
            bus.en       = vecs[i].en;
            bus.mode     = vecs[i].mode;
            bus.dir      = vecs[i].dir;
            bus.load     = vecs[i].load;
            bus.load_val = vecs[i].lv;
            @(posedge clk);
            #1;
            check_outputs(vecs[i].name, vecs[i].cnt, vecs[i].idx, vecs[i].wrap, vecs[i].ill);
        end

        // Mode flip with cnt=0011: illegal must rise before any clock edge.
        @(negedge clk);
        bus.en   = 1'b0;
        bus.load = 1'b0;
        bus.mode = 1'b1;
        #1;
        check_outputs("mode_flip", 4'b0011, 0, 0, 1);
        @(negedge clk);
        check_outputs("mode_hold", 4'b0011, 0, 0, 1);
        bus.en = 1'b1;
        @(posedge clk);
        #1;
`ifdef JOHNSON_SELFCORRECT_EN
        check_outputs("mode_fix", 4'b0001, 0, 0, 0);
`else
        check_outputs("mode_fix", 4'b0110, 0, 0, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
